cic_agc: RTL and testbench



---
 rtl/cic_agc.sv | 122 ++++++++++++
 tb/tb_cic_agc.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cic_agc.sv
// cic_agc: automatic gain control for an I/Q pair of CIC decimators (fast clip attack, windowed slow rise, manual override)
module cic_agc #(
  parameter int BITS       = 16,
  parameter int GAIN_BITS  = 8,
  parameter int MAX_GAIN   = 42,
  parameter int INIT_GAIN  = 0,
  parameter int WINDOW     = 256,
  parameter int HOLDOFF    = 8,
  parameter int CLIP_LEVEL = 16384,
  parameter int LOW_LEVEL  = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [GAIN_BITS-1:0]  manual_gain,
  input  logic signed [BITS-1:0] i_in,
  input  logic signed [BITS-1:0] q_in,
  input  logic                  in_tick,
  output logic [GAIN_BITS-1:0]  gain,
  output logic                  gain_update,
  output logic                  overload,
  output logic [BITS-1:0]       peak
);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int WW = $clog2(WINDOW);
  localparam logic [GAIN_BITS-1:0] GMAX = GAIN_BITS'(MAX_GAIN);
  localparam logic [GAIN_BITS-1:0] GINIT = GAIN_BITS'(INIT_GAIN > MAX_GAIN ? MAX_GAIN : INIT_GAIN);
  localparam logic [BITS-1:0] CLIP = BITS'(CLIP_LEVEL);
  localparam logic [BITS-1:0] LOW = BITS'(LOW_LEVEL);
  localparam logic [HW-1:0] HINIT = HW'(HOLDOFF);
  localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);
  typedef enum logic [1:0] {MANUAL, HOLD, TRACK} state_t;
  state_t state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [WW-1:0] win_cnt, win_n;
  logic [BITS-1:0] acc, acc_n, peak_n, ma, mb, m, pk;
  logic [GAIN_BITS-1:0] gain_n, mclamp;
  logic upd_n, ovl_n, clip;
  // the most negative code has no positive twin, so it saturates
  function automatic logic [BITS-1:0] mag(input logic signed [BITS-1:0] x);
    return x[BITS-1] ? ((x == {1'b1, {(BITS-1){1'b0}}}) ? {1'b0, {(BITS-1){1'b1}}} : BITS'(-x)) : x;
  endfunction
  assign ma = mag(i_in);
  assign mb = mag(q_in);
  assign m = ma > mb ? ma : mb;
  assign clip = m >= CLIP;
  assign pk = acc > m ? acc : m;
  assign mclamp = manual_gain > GMAX ? GMAX : manual_gain;
  always_comb begin
    state_n = state;
    hold_n = hold_cnt;
    win_n = win_cnt;
    acc_n = acc;
    gain_n = gain;
    peak_n = peak;
    upd_n = 1'b0;
    ovl_n = in_tick && clip && gain == '0;
    if (!enable) begin
      state_n = MANUAL;
      gain_n = mclamp;
      upd_n = mclamp != gain;
      win_n = '0;
      acc_n = '0;
    end else case (state)
      MANUAL: begin
        state_n = HOLD;
        hold_n = HINIT;
      end
      HOLD: if (in_tick) begin
        hold_n = hold_cnt - 1'b1;
        if (hold_cnt == HW'(1)) begin
          state_n = TRACK;
          win_n = '0;
          acc_n = '0;
        end
      end
      default: if (in_tick) begin
        if (clip && gain != '0) begin
          gain_n = gain - 1'b1;
          upd_n = 1'b1;
          state_n = HOLD;
          hold_n = HINIT;
          win_n = '0;
          acc_n = '0;
        end else if (win_cnt == WLAST) begin
          peak_n = pk;
          win_n = '0;
          acc_n = '0;
          if (pk < LOW && gain < GMAX) begin
            gain_n = gain + 1'b1;
            upd_n = 1'b1;
            state_n = HOLD;
            hold_n = HINIT;
          end
        end else begin
          win_n = win_cnt + 1'b1;
          acc_n = pk;
        end
      end
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= HOLD;
      hold_cnt <= HINIT;
      win_cnt <= '0;
      acc <= '0;
      gain <= GINIT;
      peak <= '0;
      gain_update <= 1'b0;
      overload <= 1'b0;
    end else begin
      state <= state_n;
      hold_cnt <= hold_n;
      win_cnt <= win_n;
      acc <= acc_n;
      gain <= gain_n;
      peak <= peak_n;
      gain_update <= upd_n;
      overload <= ovl_n;
    end
endmodule

// File: tb/tb_cic_agc.sv
// tb_cic_agc: directed-vector bench for cic_agc with hand-computed expectations
module tb_cic_agc;
  logic CLK = 0, RST = 0, enable = 1, in_tick = 0;
  logic [7:0] manual_gain = 0;
  logic signed [15:0] i_in = 0, q_in = 0;
  logic [7:0] gain;
  logic gain_update, overload;
  logic [15:0] peak;
  int vectors = 0, miscompares = 0;
  int u, tot;

  cic_agc #(.INIT_GAIN(10)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .manual_gain(manual_gain),
    .i_in(i_in), .q_in(q_in), .in_tick(in_tick),
    .gain(gain), .gain_update(gain_update), .overload(overload), .peak(peak)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n, input logic signed [15:0] i, input logic signed [15:0] q, output int ups);
    ups = 0;
    for (int k = 0; k < n; k++) begin
      i_in = i;
      q_in = q;
      in_tick = 1;
      step();
      ups += int'(gain_update);
    end
    in_tick = 0;
  endtask

  task automatic enter_track(input logic [7:0] g);
    int x;
    enable = 0;
    manual_gain = g;
    step();
    enable = 1;
    step();
    run(8, 0, 0, x);
  endtask

  task automatic test_reset();
    #2 RST = 1;
    #1;
    vectors++; if (gain !== 8'd10) begin miscompares++; $display("FAIL reset_gain: got %0d expected 10", gain); end
    vectors++; if (gain_update !== 1'b0 || overload !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: got upd=%b ovl=%b expected 0 0", gain_update, overload); end
    vectors++; if (peak !== 16'd0) begin miscompares++; $display("FAIL reset_peak: got %0d expected 0", peak); end
    step();
    RST = 0;
  endtask

  task automatic test_window_rise();
    run(8, 1000, -200, u);
    vectors++; if (gain !== 8'd10 || u != 0) begin miscompares++; $display("FAIL hold_nochange: got gain=%0d ups=%0d expected 10 0", gain, u); end
    run(255, 1000, -200, u);
    vectors++; if (gain !== 8'd10 || u != 0) begin miscompares++; $display("FAIL window_early: got gain=%0d ups=%0d expected 10 0", gain, u); end
    run(1, 1000, -200, u);
    vectors++; if (gain !== 8'd11 || gain_update !== 1'b1) begin miscompares++; $display("FAIL window_rise: got gain=%0d upd=%b expected 11 1", gain, gain_update); end
    vectors++; if (peak !== 16'd1000) begin miscompares++; $display("FAIL window_peak: got %0d expected 1000", peak); end
    step();
    vectors++; if (gain_update !== 1'b0) begin miscompares++; $display("FAIL upd_one_cycle: got %b expected 0", gain_update); end
    run(264, 1000, -200, u);
    vectors++; if (gain !== 8'd12 || u != 1) begin miscompares++; $display("FAIL second_rise: got gain=%0d ups=%0d expected 12 1", gain, u); end
  endtask

  task automatic test_clip();
    enter_track(20);
    run(1, 0, -20000, u);
    vectors++; if (gain !== 8'd19 || gain_update !== 1'b1) begin miscompares++; $display("FAIL clip_drop: got gain=%0d upd=%b expected 19 1", gain, gain_update); end
    run(8, 30000, 30000, u);
    vectors++; if (gain !== 8'd19 || u != 0) begin miscompares++; $display("FAIL clip_holdoff: got gain=%0d ups=%0d expected 19 0", gain, u); end
    run(1, 30000, 0, u);
    vectors++; if (gain !== 8'd18 || u != 1) begin miscompares++; $display("FAIL clip_after_hold: got gain=%0d ups=%0d expected 18 1", gain, u); end
  endtask

  task automatic test_overload();
    enable = 0;
    manual_gain = 0;
    step();
    run(1, 20000, 0, u);
    vectors++; if (overload !== 1'b1 || gain !== 8'd0) begin miscompares++; $display("FAIL ovl_manual: got ovl=%b gain=%0d expected 1 0", overload, gain); end
    enable = 1;
    step();
    run(8, 0, 0, u);
    run(1, -32768, 0, u);
    vectors++; if (overload !== 1'b1 || gain !== 8'd0 || gain_update !== 1'b0) begin miscompares++; $display("FAIL ovl_track: got ovl=%b gain=%0d upd=%b expected 1 0 0", overload, gain, gain_update); end
    step();
    vectors++; if (overload !== 1'b0) begin miscompares++; $display("FAIL ovl_one_cycle: got %b expected 0", overload); end
    run(254, 100, 100, u);
    vectors++; if (peak !== 16'd1000) begin miscompares++; $display("FAIL ovl_window_early: got peak=%0d expected 1000", peak); end
    run(1, 100, 100, u);
    vectors++; if (peak !== 16'd32767 || gain !== 8'd0) begin miscompares++; $display("FAIL ovl_window_peak: got peak=%0d gain=%0d expected 32767 0", peak, gain); end
  endtask

  task automatic test_no_rise();
    enter_track(30);
    tot = 0;
    for (int k = 0; k < 128; k++) begin
      run(1, 5000, 0, u); tot += u;
      run(1, 100, -100, u); tot += u;
    end
    vectors++; if (peak !== 16'd5000 || gain !== 8'd30 || tot != 0) begin miscompares++; $display("FAIL loud_window: got peak=%0d gain=%0d ups=%0d expected 5000 30 0", peak, gain, tot); end
    enter_track(42);
    run(256, 0, 0, u);
    vectors++; if (peak !== 16'd0 || gain !== 8'd42 || u != 0) begin miscompares++; $display("FAIL max_gain: got peak=%0d gain=%0d ups=%0d expected 0 42 0", peak, gain, u); end
  endtask

  task automatic test_manual();
    enable = 0;
    manual_gain = 5;
    step();
    manual_gain = 60;
    step();
    vectors++; if (gain !== 8'd42 || gain_update !== 1'b1) begin miscompares++; $display("FAIL manual_clamp: got gain=%0d upd=%b expected 42 1", gain, gain_update); end
    step();
    vectors++; if (gain_update !== 1'b0) begin miscompares++; $display("FAIL manual_steady: got upd=%b expected 0", gain_update); end
    manual_gain = 5;
    step();
    vectors++; if (gain !== 8'd5 || gain_update !== 1'b1) begin miscompares++; $display("FAIL manual_set: got gain=%0d upd=%b expected 5 1", gain, gain_update); end
    enable = 1;
    step();
    run(8, 30000, 30000, u);
    vectors++; if (gain !== 8'd5 || u != 0) begin miscompares++; $display("FAIL reenable_hold: got gain=%0d ups=%0d expected 5 0", gain, u); end
    run(255, 200, 0, u);
    vectors++; if (gain !== 8'd5 || u != 0) begin miscompares++; $display("FAIL reenable_early: got gain=%0d ups=%0d expected 5 0", gain, u); end
    run(1, 200, 0, u);
    vectors++; if (gain !== 8'd6 || peak !== 16'd200) begin miscompares++; $display("FAIL reenable_rise: got gain=%0d peak=%0d expected 6 200", gain, peak); end
  endtask

  task automatic test_reset_mid();
    enter_track(25);
    run(100, 0, 0, u);
    #2 RST = 1;
    #1;
    vectors++; if (gain !== 8'd10 || peak !== 16'd0 || gain_update !== 1'b0 || overload !== 1'b0) begin miscompares++; $display("FAIL async_reset: got gain=%0d peak=%0d upd=%b ovl=%b expected 10 0 0 0", gain, peak, gain_update, overload); end
    step();
    RST = 0;
    run(263, 0, 0, u);
    vectors++; if (gain !== 8'd10 || u != 0) begin miscompares++; $display("FAIL post_reset_wait: got gain=%0d ups=%0d expected 10 0", gain, u); end
    run(1, 0, 0, u);
    vectors++; if (gain !== 8'd11 || u != 1) begin miscompares++; $display("FAIL post_reset_rise: got gain=%0d ups=%0d expected 11 1", gain, u); end
  endtask

  initial begin
    test_reset();
    test_window_rise();
    test_clip();
    test_overload();
    test_no_rise();
    test_manual();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
